// File: rtl/stepper_pulse_gen.sv
// stepper_pulse_gen: per-axis STEP/DIR/EN pulse generator fed from the HPS
// stepper PIO registers. Optional absolute position tracking is compiled in
// when STEPPER_POS_EN is defined (adds pos_clr input and position output).
module stepper_pulse_gen #(
  parameter int unsigned PULSE_W     = 100,
  parameter int unsigned DIR_SETUP   = 50,
  parameter int unsigned MIN_PERIOD  = 200,
  parameter logic        ENDSTOP_DIR = 1'b0
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] cmd_steps,
  input  logic [31:0] cmd_period,
  input  logic        cmd_go,
  input  logic        cmd_abort,
  input  logic        endstop,
`ifdef STEPPER_POS_EN
  input  logic        pos_clr,
  output logic [31:0] position,
`endif
  output logic        step,
  output logic        dir,
  output logic        drv_en_n,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [31:0] steps_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIR_SETUP,
    S_PULSE_HIGH,
    S_PULSE_LOW
  } state_t;

  localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP - 1);
  localparam logic [31:0] HIGH_LAST  = 32'(PULSE_W - 1);
  localparam logic [31:0] PULSE_W_L  = 32'(PULSE_W);
  localparam logic [31:0] MIN_PER_L  = 32'(MIN_PERIOD);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] mag_q, mag_d;
  logic [31:0] per_q, per_d;
  logic [31:0] steps_done_q, steps_done_d;
  logic        dir_q, dir_d;
  logic        step_q, step_d;
  logic        en_n_q, en_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        abort_pend_q, abort_pend_d;
  logic        zero_pend_q, zero_pend_d;

  logic go_meta_q, go_sync_q, go_prev_q;
  logic ab_meta_q, ab_sync_q;
  logic es_meta_q, es_sync_q;

  logic        go_edge;
  logic        abort_req;
  logic [31:0] cmd_mag;
  logic [31:0] cmd_per;

  // Two-flop synchronizers for the asynchronous control inputs, plus go history.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      go_meta_q <= 1'b0;
      go_sync_q <= 1'b0;
      go_prev_q <= 1'b0;
      ab_meta_q <= 1'b0;
      ab_sync_q <= 1'b0;
      es_meta_q <= 1'b0;
      es_sync_q <= 1'b0;
    end else begin
      go_meta_q <= cmd_go;
      go_sync_q <= go_meta_q;
      go_prev_q <= go_sync_q;
      ab_meta_q <= cmd_abort;
      ab_sync_q <= ab_meta_q;
      es_meta_q <= endstop;
      es_sync_q <= es_meta_q;
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mag_q        <= '0;
      per_q        <= '0;
      steps_done_q <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      en_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      zero_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mag_q        <= mag_d;
      per_q        <= per_d;
      steps_done_q <= steps_done_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      en_n_q       <= en_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      zero_pend_q  <= zero_pend_d;
    end
  end

  // Next-state logic: command accept, phase timing, abort handling.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mag_d        = mag_q;
    per_d        = per_q;
    steps_done_d = steps_done_q;
    dir_d        = dir_q;
    step_d       = step_q;
    en_n_d       = en_n_q;
    busy_d       = busy_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    zero_pend_d  = 1'b0;

    go_edge   = go_sync_q & ~go_prev_q;
    abort_req = ab_sync_q | (es_sync_q & (dir_q == ENDSTOP_DIR) & busy_q);
    cmd_mag   = cmd_steps[31] ? (32'd0 - cmd_steps) : cmd_steps;
    cmd_per   = (cmd_period < MIN_PER_L) ? MIN_PER_L : cmd_period;

    // A zero-length move reports done one cycle after it was accepted.
    if (zero_pend_q) begin
      done_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (go_edge) begin
          dir_d        = cmd_steps[31];
          mag_d        = cmd_mag;
          per_d        = cmd_per;
          steps_done_d = '0;
          done_d       = 1'b0;
          aborted_d    = 1'b0;
          en_n_d       = 1'b0;
          cnt_d        = '0;
          abort_pend_d = 1'b0;
          if (cmd_mag == '0) begin
            zero_pend_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_DIR_SETUP;
          end
        end
      end

      S_DIR_SETUP: begin
        if (abort_req) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (cnt_q == SETUP_LAST) begin
          cnt_d        = '0;
          step_d       = 1'b1;
          steps_done_d = steps_done_q + 32'd1;
          state_d      = S_PULSE_HIGH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // An abort here is remembered so the pulse is never truncated.
      S_PULSE_HIGH: begin
        if (abort_req) begin
          abort_pend_d = 1'b1;
        end
        if (cnt_q == HIGH_LAST) begin
          cnt_d  = '0;
          step_d = 1'b0;
          if (abort_pend_q || abort_req) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
          end else begin
            state_d = S_PULSE_LOW;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // Abort is tested before completion so it wins a same-cycle tie.
      S_PULSE_LOW: begin
        if (abort_req) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (cnt_q == per_q - PULSE_W_L - 32'd1) begin
          cnt_d = '0;
          if (steps_done_q == mag_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            step_d       = 1'b1;
            steps_done_d = steps_done_q + 32'd1;
            state_d      = S_PULSE_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef STEPPER_POS_EN
  logic [31:0] position_q;

  // Absolute position follows each STEP rise; a clear request takes priority.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      position_q <= '0;
    end else if (pos_clr) begin
      position_q <= '0;
    end else if (step_d && !step_q) begin
      position_q <= dir_q ? (position_q - 32'd1) : (position_q + 32'd1);
    end
  end

  assign position = position_q;
`endif

  assign step       = step_q;
  assign dir        = dir_q;
  assign drv_en_n   = en_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_done = steps_done_q;

endmodule
